uart_rx_os: RTL and testbench
=============================

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter BAUD_DIVIDER, default 104, clk cycles per bit period (legal range 4..65535).
REQ-002 SHALL have port clk, input, 1, the system clock; the block uses one clock domain.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Rx, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port O_DATA, output, 8, last correctly framed byte.
REQ-006 SHALL have port NrD, output, 1, one-cycle pulse meaning a new byte is valid on O_DATA.
REQ-007 SHALL have port FrE, output, 1, one-cycle pulse meaning a framing error (stop bit sampled low).
REQ-008 SHALL have port RiP, output, 1, reception in progress: high in every state except IDLE.

Function
REQ-009 SHALL pass Rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-010 SHALL use one bit-timing counter, width ceil(log2(BAUD_DIVIDER)), and a 3-bit bit index; both clear on every state entry.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 IDLE: rx_s==0 -> START.
REQ-013 START: at counter==floor(BAUD_DIVIDER/2)-1, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at counter==BAUD_DIVIDER-1, shift rx_s into bit 7 of the shift register (right shift, LSB first), increment bit index, clear counter; after the 8th sample -> STOP.
REQ-015 STOP: at counter==BAUD_DIVIDER-1, sample rx_s; 1 -> load O_DATA from the shift register, pulse NrD, -> IDLE.
REQ-016 STOP: at the same sample point, rx_s==0 -> pulse FrE, leave O_DATA unchanged, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: rx_s==1 -> IDLE; the block SHALL NOT detect a start bit before the line returns high.
REQ-018 NrD and FrE SHALL be registered, high for exactly one clk, in the cycle after the stop-bit sample; they are never high together.
REQ-019 O_DATA SHALL change only in the same cycle that NrD asserts, and SHALL hold until the next valid frame.
REQ-020 The block SHALL have no backpressure; a new frame overwrites O_DATA regardless of consumer state.
REQ-021 Back-to-back frames: a start edge seen in the cycle IDLE is re-entered after STOP SHALL be accepted, so a one-stop-bit gap is sufficient.
REQ-022 NrD SHALL assert between 9*BAUD_DIVIDER+floor(BAUD_DIVIDER/2) and that value +4 clk cycles after the Rx falling edge.

Reset
REQ-023 rst SHALL force, on the next clk edge: state IDLE; counter, bit index and shift register 0; synchronizer flops 1; O_DATA 0x00; NrD, FrE and RiP 0.
REQ-024 rst asserted mid-frame SHALL abandon the frame without any NrD or FrE pulse; rst has priority over all other events.

Verification (BAUD_DIVIDER=8)
REQ-025 Frame 0xA5 with a valid stop bit -> a single NrD pulse, O_DATA=0xA5, FrE never high, RiP low after completion.
REQ-026 Rx low for 2 clk, then high -> RiP returns to 0 by the START sample point; no NrD or FrE; O_DATA unchanged.
REQ-027 After 0x3C is received, frame 0x81 with stop bit 0, then the line held low for 20 bit times -> a single FrE pulse; O_DATA stays 0x3C; RiP stays high until Rx goes high.
REQ-028 Frames 0x00 then 0xFF, back-to-back with one stop bit -> two NrD pulses, O_DATA 0x00 then 0xFF.
REQ-029 rst pulsed during bit 4 of a frame -> all outputs 0 the next cycle, no pulses; the following frame 0x5A is received correctly.
REQ-030 Sweep BAUD_DIVIDER in {4, 8, 104} with random bytes and ±3% bit-period skew -> every byte is received without error.

Source files
------------

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver, one clock domain; start bit checked at half a bit, data and stop bits one full bit apart.
// NrD/FrE are one-cycle registered pulses; there is no backpressure, a new frame simply overwrites O_DATA.
module uart_rx_os #(
  parameter int BAUD_DIVIDER = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic [7:0] O_DATA,
  output logic       NrD,
  output logic       FrE,
  output logic       RiP
);

  localparam int CW = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIVIDER / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIVIDER - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic [7:0]      data_q;
  logic            nrd_q;
  logic            fre_q;
  logic            rip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      nrd_q     <= 1'b0;
      fre_q     <= 1'b0;
      rip_q     <= 1'b0;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
      nrd_q     <= 1'b0;
      fre_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            bit_q   <= '0;
            rip_q   <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              rip_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            sh_q  <= {rx_s_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (rx_s_q) begin
              data_q  <= sh_q;
              nrd_q   <= 1'b1;
              state_q <= IDLE;
              rip_q   <= 1'b0;
            end else begin
              fre_q   <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_HIGH: begin
          // A line stuck low must not be mistaken for a fresh start bit.
          if (rx_s_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            rip_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          bit_q   <= '0;
          rip_q   <= 1'b0;
        end
      endcase
    end
  end

  assign O_DATA = data_q;
  assign NrD    = nrd_q;
  assign FrE    = fre_q;
  assign RiP    = rip_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances (divider 4, 8, 104) on separate Rx lines,
// a vector table on the divider-8 instance plus hand-written corner-case sequences.
module tb_uart_rx_os;

  logic       clk;
  logic       rst;
  logic [2:0] rx;
  logic [7:0] odata [3];
  logic [2:0] nrd;
  logic [2:0] fre;
  logic [2:0] rip;

  int total;
  int bad;
  int cyc;
  int bd [3];
  int nrd_cnt [3];
  int fre_cnt [3];
  int nrd_cyc [3];
  int fall_cyc [3];
  logic [7:0] log_dat [3][64];
  logic [7:0] prev_od [3];
  logic       rst_at_edge;

  uart_rx_os #(.BAUD_DIVIDER(4)) u_d4 (
    .clk(clk), .rst(rst), .Rx(rx[0]), .O_DATA(odata[0]), .NrD(nrd[0]), .FrE(fre[0]), .RiP(rip[0])
  );
  uart_rx_os #(.BAUD_DIVIDER(8)) u_d8 (
    .clk(clk), .rst(rst), .Rx(rx[1]), .O_DATA(odata[1]), .NrD(nrd[1]), .FrE(fre[1]), .RiP(rip[1])
  );
  uart_rx_os #(.BAUD_DIVIDER(104)) u_d104 (
    .clk(clk), .rst(rst), .Rx(rx[2]), .O_DATA(odata[2]), .NrD(nrd[2]), .FrE(fre[2]), .RiP(rip[2])
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge = rst;
  end

  // Pulse counting, pulse exclusivity and O_DATA stability, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (nrd[i] === 1'b1) begin
        log_dat[i][nrd_cnt[i] % 64] = odata[i];
        nrd_cnt[i] = nrd_cnt[i] + 1;
        nrd_cyc[i] = cyc;
      end
      if (fre[i] === 1'b1) fre_cnt[i] = fre_cnt[i] + 1;
      if (nrd[i] === 1'b1 && fre[i] === 1'b1) begin
        total++;
        bad++;
        $display("FAIL pulse_overlap dut%0d: NrD and FrE both high, required never together", i);
      end
      if (odata[i] !== prev_od[i]) begin
        total++;
        if (!(nrd[i] === 1'b1 || (rst_at_edge === 1'b1 && odata[i] === 8'h00))) begin
          bad++;
          $display("FAIL odata_stable dut%0d: O_DATA changed to %02h without NrD", i, odata[i]);
        end
        prev_od[i] = odata[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int idx, input logic [7:0] d, input logic stop,
                            input int skew, input bit align);
    int bitp;
    bitp = bd[idx] * (100 + skew);
    // Falling edge lands just before a clock edge so sample phases are deterministic.
    if (align) begin
      @(posedge clk);
      #90;
    end
    rx[idx] = 1'b0;
    fall_cyc[idx] = cyc;
    #(bitp);
    for (int k = 0; k < 8; k++) begin
      rx[idx] = d[k];
      #(bitp);
    end
    rx[idx] = stop;
    #(bitp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         skew;
    logic [7:0] exp_data;
    int         exp_nrd;
    int         exp_fre;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n0, f0, lat;
    logic [7:0] rb [6];

    total = 0; bad = 0; cyc = 0;
    bd[0] = 4; bd[1] = 8; bd[2] = 104;
    for (int i = 0; i < 3; i++) begin
      nrd_cnt[i] = 0; fre_cnt[i] = 0; nrd_cyc[i] = 0; fall_cyc[i] = 0; prev_od[i] = 8'h00;
    end
    rst_at_edge = 1'b1;
    rx  = 3'b111;
    rst = 1'b1;

    vecs[0] = '{8'hA5, 1'b1,  0, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b1,  0, 8'h3C, 1, 0};
    vecs[2] = '{8'h81, 1'b0,  0, 8'h3C, 0, 1};
    vecs[3] = '{8'h00, 1'b1,  3, 8'h00, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, -3, 8'hFF, 1, 0};
    vecs[5] = '{8'h5A, 1'b0, -3, 8'hFF, 0, 1};
    vecs[6] = '{8'hC3, 1'b1,  3, 8'hC3, 1, 0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_odata_d%0d", i), 32'(odata[i]), 32'h00);
      chk($sformatf("reset_flags_d%0d", i), {29'd0, nrd[i], fre[i], rip[i]}, 32'h0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      n0 = nrd_cnt[1]; f0 = fre_cnt[1];
      send_frame(1, vecs[v].data, vecs[v].stop, vecs[v].skew, 1'b1);
      repeat (12) @(negedge clk);
      if (!vecs[v].stop) begin
        chk($sformatf("vec%0d_rip_waithigh", v), 32'(rip[1]), 32'h1);
        rx[1] = 1'b1;
        repeat (4) @(negedge clk);
      end
      chk($sformatf("vec%0d_odata", v), 32'(odata[1]), 32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_nrd_cnt", v), 32'(nrd_cnt[1] - n0), 32'(vecs[v].exp_nrd));
      chk($sformatf("vec%0d_fre_cnt", v), 32'(fre_cnt[1] - f0), 32'(vecs[v].exp_fre));
      chk($sformatf("vec%0d_rip_idle", v), 32'(rip[1]), 32'h0);
    end

    // Framing error with the line then held low for 20 bit times.
    send_frame(1, 8'h3C, 1'b1, 0, 1'b1);
    repeat (12) @(negedge clk);
    chk("fe_pre_odata", 32'(odata[1]), 32'h3C);
    n0 = nrd_cnt[1]; f0 = fre_cnt[1];
    send_frame(1, 8'h81, 1'b0, 0, 1'b1);
    #(20 * 800);
    chk("fe_fre_cnt", 32'(fre_cnt[1] - f0), 32'h1);
    chk("fe_nrd_cnt", 32'(nrd_cnt[1] - n0), 32'h0);
    chk("fe_odata", 32'(odata[1]), 32'h3C);
    chk("fe_rip_low_line", 32'(rip[1]), 32'h1);
    rx[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("fe_rip_released", 32'(rip[1]), 32'h0);

    // Latency from the Rx falling edge to NrD: 9*8+4 .. +4 cycles.
    send_frame(1, 8'h96, 1'b1, 0, 1'b1);
    repeat (12) @(negedge clk);
    chk("lat_odata", 32'(odata[1]), 32'h96);
    lat = nrd_cyc[1] - fall_cyc[1];
    chk("lat_in_window", 32'((lat >= 76) && (lat <= 80)), 32'h1);

    // Two-cycle glitch: START rejects it at the half-bit sample.
    n0 = nrd_cnt[1]; f0 = fre_cnt[1];
    @(posedge clk);
    #90 rx[1] = 1'b0;
    #210 rx[1] = 1'b1;
    #150;
    chk("glitch_rip_start", 32'(rip[1]), 32'h1);
    #300;
    chk("glitch_rip_back", 32'(rip[1]), 32'h0);
    repeat (20) @(negedge clk);
    chk("glitch_no_pulses", 32'((nrd_cnt[1] - n0) + (fre_cnt[1] - f0)), 32'h0);
    chk("glitch_odata", 32'(odata[1]), 32'h96);

    // Back-to-back frames, second start edge exactly one stop bit after the first.
    n0 = nrd_cnt[1];
    send_frame(1, 8'h00, 1'b1, 0, 1'b1);
    send_frame(1, 8'hFF, 1'b1, 0, 1'b0);
    repeat (12) @(negedge clk);
    chk("b2b_nrd_cnt", 32'(nrd_cnt[1] - n0), 32'h2);
    chk("b2b_first", 32'(log_dat[1][n0 % 64]), 32'h00);
    chk("b2b_second", 32'(log_dat[1][(n0 + 1) % 64]), 32'hFF);

    // Reset in the middle of data bit 4; the rest of 0xF0 keeps the line high.
    n0 = nrd_cnt[1]; f0 = fre_cnt[1];
    fork
      send_frame(1, 8'hF0, 1'b1, 0, 1'b1);
      begin
        @(posedge clk);
        #90;
        #(5 * 800 + 400);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_odata", 32'(odata[1]), 32'h00);
        chk("rst_mid_flags", {29'd0, nrd[1], fre[1], rip[1]}, 32'h0);
        rst = 1'b0;
      end
    join
    repeat (12) @(negedge clk);
    chk("rst_mid_no_pulses", 32'((nrd_cnt[1] - n0) + (fre_cnt[1] - f0)), 32'h0);
    send_frame(1, 8'h5A, 1'b1, 0, 1'b1);
    repeat (12) @(negedge clk);
    chk("rst_after_odata", 32'(odata[1]), 32'h5A);
    chk("rst_after_nrd", 32'(nrd_cnt[1] - n0), 32'h1);

    // Divider sweep with random bytes and -3%/0/+3% bit period skew.
    for (int d = 0; d < 3; d++) begin
      n0 = nrd_cnt[d]; f0 = fre_cnt[d];
      for (int k = 0; k < 6; k++) begin
        rb[k] = 8'($urandom_range(255, 0));
        send_frame(d, rb[k], 1'b1, (k % 3) * 3 - 3, 1'b1);
      end
      repeat (bd[d] + 12) @(negedge clk);
      chk($sformatf("sweep_d%0d_nrd_cnt", bd[d]), 32'(nrd_cnt[d] - n0), 32'h6);
      chk($sformatf("sweep_d%0d_fre_cnt", bd[d]), 32'(fre_cnt[d] - f0), 32'h0);
      for (int k = 0; k < 6; k++)
        chk($sformatf("sweep_d%0d_byte%0d", bd[d], k), 32'(log_dat[d][(n0 + k) % 64]), 32'(rb[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
